// File: rtl/cpu_pkg.sv
// Shared definitions for the Minisys-style fetch path: FSM encoding,
// reset PC default, instruction field positions and the control bundle.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Jump-target field of j/jal instructions.
  localparam int JTGT_MSB = 25;
  localparam int JTGT_LSB = 0;

  // Jump/branch controls sampled in the retire cycle.
  typedef struct packed {
    logic branch;
    logic nbranch;
    logic jmp;
    logic jal;
    logic jrn;
  } ctrl_t;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority mux: jr > j/jal > taken branch > pc+4.
// Also flags a jr target that is not word aligned.
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic [31:0] i_pc_plus_4,
  input  logic [25:0] i_jump_target,
  input  logic [29:0] i_branch_target,
  input  logic [31:0] i_read_data_1,
  input  logic        i_zero,
  input  ctrl_t       i_ctrl,
  output logic [31:0] o_next_pc,
  output logic        o_misaligned
);

  logic w_branch_taken;

  assign w_branch_taken = (i_ctrl.branch & i_zero) | (i_ctrl.nbranch & ~i_zero);

  // Priority selection of the next program counter.
  always_comb begin
    // NOTE: every output gets a default before the if-chain so no path leaves
    // it unassigned, which would otherwise infer a latch.
    o_next_pc    = i_pc_plus_4;
    o_misaligned = 1'b0;
    if (i_ctrl.jrn) begin
      o_next_pc    = {i_read_data_1[31:2], 2'b00};
      o_misaligned = |i_read_data_1[1:0];
    end else if (i_ctrl.jmp | i_ctrl.jal) begin
      o_next_pc = {i_pc_plus_4[31:28], i_jump_target, 2'b00};
    end else if (w_branch_taken) begin
      o_next_pc = {i_branch_target, 2'b00};
    end
  end

endmodule

// File: rtl/ifetch_seq.sv
// Sequential instruction-fetch unit: holds the PC, fetches one word per
// instruction over a req/ack handshake, and issues it until retired.
module ifetch_seq
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        add_result,
  input  logic               zero,
  input  logic [31:0]        read_data_1,
  input  logic               branch,
  input  logic               nbranch,
  input  logic               jmp,
  input  logic               jal,
  input  logic               jrn,
  input  logic               stall,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instruction,
  output logic               instr_valid,
  output logic [31:0]        pc_plus_4,
  output logic [31:0]        link_addr,
  output logic               misaligned
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_instruction;
  logic        r_instr_valid;
  logic [31:0] r_link_addr;
  logic        r_misaligned;

  logic        w_imem_req;
  logic        w_retire;
  logic        w_take_ack;
  logic [31:0] w_pc_plus_4;
  logic [31:0] w_next_pc;
  logic        w_next_misaligned;
  ctrl_t       w_ctrl;
  logic        w_unused_add_result;

  // Branch target arrives as a word address; its top two bits fall off the
  // 32-bit byte address.
  assign w_unused_add_result = &{1'b0, add_result[31:30]};

  assign w_ctrl      = '{branch: branch, nbranch: nbranch, jmp: jmp, jal: jal, jrn: jrn};
  assign w_pc_plus_4 = r_pc + 32'd4;
  assign w_retire    = (r_state == ISSUE) && !stall;
  assign w_take_ack  = (r_state == FETCH) && imem_ack;

  next_pc_sel u_next_pc_sel (
    .i_pc_plus_4     (w_pc_plus_4),
    .i_jump_target   (r_instruction[JTGT_MSB:JTGT_LSB]),
    .i_branch_target (add_result[29:0]),
    .i_read_data_1   (read_data_1),
    .i_zero          (zero),
    .i_ctrl          (w_ctrl),
    .o_next_pc       (w_next_pc),
    .o_misaligned    (w_next_misaligned)
  );

  // Next-state and request decode; IDLE always yields one request-free cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_imem_req  = 1'b0;
    case (r_state)
      IDLE:    w_state_nxt = FETCH;
      FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ack) w_state_nxt = ISSUE;
      end
      ISSUE:   if (!stall) w_state_nxt = FETCH;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any outstanding request.
  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous here, so it only appears inside the clocked
    // block and never in the sensitivity list.
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // PC, issued instruction, link register and misalignment pulse.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values, regardless of statement order.
    if (reset) begin
      r_pc          <= RESET_PC;
      r_instruction <= 32'h0;
      r_instr_valid <= 1'b0;
      r_link_addr   <= 32'h0;
      r_misaligned  <= 1'b0;
    end else begin
      r_misaligned <= w_retire && w_next_misaligned;
      if (w_take_ack) begin
        r_instruction <= imem_rdata;
        r_instr_valid <= 1'b1;
      end
      if (w_retire) begin
        r_pc          <= w_next_pc;
        r_instr_valid <= 1'b0;
        // jr outranks jal, so a jal that loses to jr leaves the link alone.
        if (jal && !jrn) r_link_addr <= w_pc_plus_4;
      end
    end
  end

  assign imem_req    = w_imem_req;
  assign imem_addr   = r_pc[IMEM_AW+1:2];
  assign instruction = r_instruction;
  assign instr_valid = r_instr_valid;
  assign pc_plus_4   = w_pc_plus_4;
  assign link_addr   = r_link_addr;
  assign misaligned  = r_misaligned;

endmodule

// File: doc/ifetch_seq.md
Name: ifetch_seq

Overview:
- Sequential instruction-fetch unit for the Minisys-style MIPS core.
- Consumes the branch target (add_result, a word address) and the zero flag produced by the execute stage, plus the jump/branch controls from the controller.
- Holds the PC and fetches each instruction from instruction memory over a req/ack handshake.
- Presents the instruction, pc_plus_4 and link_addr to decode and execute.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset; low two bits must be 0.
- IMEM_AW, 14, instruction-memory word-address width.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- add_result  in  32  branch target as a word address from execute.
- zero  in  1  ALU zero flag from execute.
- read_data_1  in  32  register rs value (byte address) for jr.
- branch  in  1  beq: taken when zero = 1.
- nbranch  in  1  bne: taken when zero = 0.
- jmp  in  1  j instruction.
- jal  in  1  jal instruction.
- jrn  in  1  jr instruction.
- stall  in  1  downstream not ready; holds the current instruction.
- imem_req  out  1  fetch request.
- imem_addr  out  IMEM_AW  word address, equal to pc[IMEM_AW+1:2].
- imem_ack  in  1  one-cycle pulse; imem_rdata is valid in that cycle.
- imem_rdata  in  32  fetched word.
- instruction  out  32  currently issued instruction (registered).
- instr_valid  out  1  instruction is valid and awaiting retirement.
- pc_plus_4  out  32  pc + 4 (combinational from the PC register).
- link_addr  out  32  byte return address captured on jal.
- misaligned  out  1  one-cycle pulse when a jr target has bits [1:0] != 0.

Behaviour:
- Reset values:
  - state IDLE, pc = RESET_PC, instruction = 0, instr_valid = 0, imem_req = 0, link_addr = 0, misaligned = 0.
  - pc_plus_4 therefore reads RESET_PC + 4.
- States:
  - IDLE: imem_req = 0. Always goes to FETCH on the next cycle, which guarantees one request-free cycle after every reset.
  - FETCH: imem_req = 1 and imem_addr stable. Stays in FETCH until imem_ack = 1. On ack, latch instruction <= imem_rdata, set instr_valid <= 1, go to ISSUE.
  - ISSUE: instr_valid = 1, imem_req = 0.
    - While stall = 1: hold every register. Control inputs are don't-care.
    - On the first cycle with stall = 0 (retire cycle): sample the controls, update pc, clear instr_valid, go to FETCH.
- Fetch latency: the minimum is 1 cycle of req before ack, so instruction-to-instruction throughput is 2 cycles when ack arrives on the first req cycle.
- Next-PC selection in the retire cycle, priority high to low:
  1. jrn: pc <= {read_data_1[31:2], 2'b00}; misaligned pulses if read_data_1[1:0] != 0.
  2. jmp or jal: pc <= {pc_plus_4[31:28], instruction[25:0], 2'b00}.
  3. (branch & zero) or (nbranch & ~zero): pc <= {add_result[29:0], 2'b00}.
  4. Otherwise: pc <= pc_plus_4.
- Simultaneous controls resolve strictly by that priority.
- jal: link_addr <= pc_plus_4 in the retire cycle. link_addr is unchanged otherwise.
- Arithmetic:
  - All PC arithmetic is 32-bit unsigned and wraps, so pc 32'hFFFF_FFFC advances to 0.
  - add_result bits [31:30] are discarded.
- Handshake rules:
  - imem_ack outside FETCH is ignored.
  - imem_req never drops in FETCH before ack.
  - imem_addr never changes while imem_req = 1.
- Reset mid-operation: a reset in any state returns to IDLE on that edge. An outstanding request is abandoned. The memory model must not ack after reset without a fresh req.

Decomposition:
- Shared package cpu_pkg:
  - state encoding: IDLE = 2'd0, FETCH = 2'd1, ISSUE = 2'd2.
  - RESET_PC default.
  - opcode field positions, for example the jump-target slice [25:0].
- One natural sub-module, next_pc_sel: purely combinational priority mux producing the next pc and the misaligned flag.
- The FSM and registers stay in ifetch_seq.

Test Plan:
- Reset, then memory ack on the first req cycle with word 32'h2001_0005 at addr 0:
  - imem_req low for 1 cycle, then high with imem_addr = 0.
  - instruction = 32'h2001_0005, instr_valid = 1, pc_plus_4 = 4.
  - After retire with no controls: imem_addr = 1.
- branch = 1, zero = 1, add_result = 32'h10 at retire → next imem_addr = 16, pc = 32'h40. Repeat with zero = 0 → pc = pc + 4. For nbranch the two zero cases invert.
- jal with instruction = 32'h0C00_0020 at pc = 32'h8 → pc = 32'h80, link_addr = 32'hC. Same retire with jrn = 1 also asserted → jr wins, and link_addr is unchanged.
- jrn with read_data_1 = 32'h0000_0103 → pc = 32'h100 and misaligned pulses for exactly 1 cycle.
- Stall held 5 cycles in ISSUE with the controls toggling → instruction, pc and instr_valid frozen; only the controls on the cycle stall drops take effect.
- Wrap and reset:
  - With pc = 32'hFFFF_FFFC and no jump → next pc = 0.
  - Assert reset during FETCH with ack delayed → next cycle state IDLE, imem_req = 0, pc = RESET_PC, instr_valid = 0.
